// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges MEM/WB writebacks with buffered mul/div results onto the
// register file's single write port and tracks pending mul/div destinations.
module writeback_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MD_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [4:0]            md_rd,
  input  logic [DATA_WIDTH-1:0] md_data,
  input  logic                  md_issue,
  input  logic [4:0]            md_issue_rd,
  output logic [31:0]           busy_mask,
  output logic                  pipe_stall,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int AW = $clog2(MD_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            fifo_rd   [MD_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [MD_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve;
  logic                  rf_from_md;

  logic                  fifo_ne;
  logic                  wb_req;
  logic                  grant_fifo;
  logic                  grant_wb;
  logic                  push;
  logic [SW-1:0]         starve_next;
  logic [31:0]           busy_next;

  // Ready depends only on the registered occupancy, never on this cycle's pop.
  assign fifo_ne    = (count != '0);
  assign md_ready   = (count != CW'(MD_FIFO_DEPTH));
  assign wb_req     = wb_valid && (wb_rd != 5'd0);
  assign grant_fifo = fifo_ne && (pipe_stall || !wb_req);
  assign grant_wb   = wb_req && !grant_fifo;
  assign push       = md_valid && md_ready && (md_rd != 5'd0);

  always_comb begin
    starve_next = '0;
    if (fifo_ne && !grant_fifo) begin
      if (starve >= SW'(STARVE_LIMIT))
        starve_next = SW'(STARVE_LIMIT);
      else
        starve_next = starve + SW'(1);
    end
  end

  // A new issue to the same register outranks the completing FIFO write.
  always_comb begin
    busy_next = busy_mask;
    if (rf_we && rf_from_md)
      busy_next[rf_rd] = 1'b0;
    if (md_issue && (md_issue_rd != 5'd0))
      busy_next[md_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= md_rd;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      pipe_stall <= 1'b0;
      busy_mask  <= '0;
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_wdata   <= '0;
      rf_from_md <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (grant_fifo)
        rd_ptr <= rd_ptr + AW'(1);
      count      <= count + CW'(push) - CW'(grant_fifo);
      starve     <= starve_next;
      pipe_stall <= (starve_next == SW'(STARVE_LIMIT));
      busy_mask  <= busy_next;
      rf_from_md <= grant_fifo;
      if (grant_fifo) begin
        rf_we    <= 1'b1;
        rf_rd    <= fifo_rd[rd_ptr];
        rf_wdata <= fifo_data[rd_ptr];
      end else if (grant_wb) begin
        rf_we    <= 1'b1;
        rf_rd    <= wb_rd;
        rf_wdata <= wb_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table, hand-written corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_rd;
  logic [DW-1:0] md_data;
  logic          md_issue;
  logic [4:0]    md_issue_rd;
  logic [31:0]   busy_mask;
  logic          pipe_stall;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter #(.DATA_WIDTH(DW), .MD_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .busy_mask(busy_mask), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;  logic [4:0] wrd; logic [31:0] wd;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        iv;  logic [4:0] ird;
    logic        ewe; logic [4:0] erd; logic [31:0] ewd;
    logic [31:0] ebusy; logic estall; logic eready;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[21];

  // Reference model: pending results as a queue, busy set as a bit array.
  ent_t        mq[$];
  bit          mpend[32];
  bit          m_we, m_from_md, m_stall;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  int          m_head_wait;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ewe, input logic [4:0] erd, input logic [31:0] ewd,
                          input logic [31:0] ebusy, input logic estall, input logic eready);
    checkOutput({tag, ".rf_we"},      32'(rf_we),      32'(ewe));
    checkOutput({tag, ".rf_rd"},      32'(rf_rd),      32'(erd));
    checkOutput({tag, ".rf_wdata"},   rf_wdata,        ewd);
    checkOutput({tag, ".busy_mask"},  busy_mask,       ebusy);
    checkOutput({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(estall));
    checkOutput({tag, ".md_ready"},   32'(md_ready),   32'(eready));
  endtask

  task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic iv, input logic [4:0] ird);
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    md_valid = mv; md_rd = mrd; md_data = md;
    md_issue = iv; md_issue_rd = ird;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = '0;
    md_issue = 1'b0; md_issue_rd = 5'd0;
  endtask

  task automatic resetDut();
    idleInputs();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic void modelReset();
    mq.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
    m_we = 1'b0; m_from_md = 1'b0; m_stall = 1'b0;
    m_rd = 5'd0; m_wd = '0; m_head_wait = 0;
  endfunction

  function automatic logic [31:0] modelBusy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = mpend[i];
    return b;
  endfunction

  // Advance the model across one clock edge given this cycle's inputs.
  function automatic void modelStep(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                                    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                    input logic iv, input logic [4:0] ird);
    bit   has_entry, pipe_wants, serve_md, accepted;
    ent_t head, incoming;
    has_entry  = (mq.size() > 0);
    pipe_wants = wv && (wrd != 5'd0);
    serve_md   = has_entry && (m_stall || !pipe_wants);
    accepted   = mv && (mq.size() < DEPTH);
    if (m_we && m_from_md) mpend[m_rd] = 1'b0;
    if (iv && (ird != 5'd0)) mpend[ird] = 1'b1;
    if (serve_md) begin
      head = mq.pop_front();
      m_we = 1'b1; m_rd = head.rd; m_wd = head.data; m_from_md = 1'b1;
    end else if (pipe_wants) begin
      m_we = 1'b1; m_rd = wrd; m_wd = wd; m_from_md = 1'b0;
    end else begin
      m_we = 1'b0; m_from_md = 1'b0;
    end
    if (has_entry && !serve_md) m_head_wait = (m_head_wait + 1 > LIMIT) ? LIMIT : m_head_wait + 1;
    else m_head_wait = 0;
    m_stall = (m_head_wait == LIMIT);
    if (accepted && (mrd != 5'd0)) begin
      incoming.rd = mrd;
      incoming.data = md;
      mq.push_back(incoming);
    end
  endfunction

  initial begin
    vecs[0]  = '{1'b1,5'd5,32'h13, 1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,5'd5,32'h13,  32'h0,  1'b0,1'b1};
    vecs[1]  = '{1'b1,5'd0,32'h77, 1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,5'd5,32'h13,  32'h0,  1'b0,1'b1};
    vecs[2]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd9, 1'b0,5'd5,32'h13,  32'h200,1'b0,1'b1};
    vecs[3]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,5'd5,32'h13,  32'h200,1'b0,1'b1};
    vecs[4]  = '{1'b0,5'd0,32'h0,  1'b1,5'd9,32'h2,  1'b0,5'd0, 1'b0,5'd5,32'h13,  32'h200,1'b0,1'b1};
    vecs[5]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,5'd9,32'h2,   32'h200,1'b0,1'b1};
    vecs[6]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,5'd9,32'h2,   32'h0,  1'b0,1'b1};
    vecs[7]  = '{1'b1,5'd8,32'h1,  1'b1,5'd10,32'h13,1'b0,5'd0, 1'b1,5'd8,32'h1,   32'h0,  1'b0,1'b1};
    vecs[8]  = '{1'b0,5'd0,32'h0,  1'b1,5'd11,32'h44,1'b0,5'd0, 1'b1,5'd10,32'h13, 32'h0,  1'b0,1'b1};
    vecs[9]  = '{1'b1,5'd4,32'h55, 1'b1,5'd12,32'h66,1'b0,5'd0, 1'b1,5'd4,32'h55,  32'h0,  1'b0,1'b0};
    vecs[10] = '{1'b1,5'd6,32'h10, 1'b1,5'd13,32'h99,1'b0,5'd0, 1'b1,5'd6,32'h10,  32'h0,  1'b0,1'b0};
    vecs[11] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,5'd11,32'h44, 32'h0,  1'b0,1'b1};
    vecs[12] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,5'd12,32'h66, 32'h0,  1'b0,1'b1};
    vecs[13] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,5'd12,32'h66, 32'h0,  1'b0,1'b1};
    vecs[14] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd3, 1'b0,5'd12,32'h66, 32'h8,  1'b0,1'b1};
    vecs[15] = '{1'b0,5'd0,32'h0,  1'b1,5'd3,32'hAB, 1'b0,5'd0, 1'b0,5'd12,32'h66, 32'h8,  1'b0,1'b1};
    vecs[16] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,5'd3,32'hAB,  32'h8,  1'b0,1'b1};
    vecs[17] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd3, 1'b0,5'd3,32'hAB,  32'h8,  1'b0,1'b1};
    vecs[18] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,5'd3,32'hAB,  32'h8,  1'b0,1'b1};
    vecs[19] = '{1'b0,5'd0,32'h0,  1'b1,5'd0,32'hFF, 1'b0,5'd0, 1'b0,5'd3,32'hAB,  32'h8,  1'b0,1'b1};
    vecs[20] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,5'd3,32'hAB,  32'h8,  1'b0,1'b1};

    idleInputs();
    reset_n = 1'b0;
    #12;
    checkAll("in_reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkAll("after_reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].mv, vecs[i].mrd, vecs[i].md,
                    vecs[i].iv, vecs[i].ird);
      checkAll($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].erd, vecs[i].ewd,
               vecs[i].ebusy, vecs[i].estall, vecs[i].eready);
    end

    // Starvation: one buffered entry loses to wb for LIMIT cycles, then a single stall.
    resetDut();
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h5A, 1'b0, 5'd0);
    checkAll("starve_enq", 1'b1, 5'd1, 32'h100, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= LIMIT; k++) begin
      applyStimulus(1'b1, 5'(k + 1), 32'h200 + 32'(k), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkAll($sformatf("starve%0d", k), 1'b1, 5'(k + 1), 32'h200 + 32'(k), 32'h0, (k == LIMIT), 1'b1);
    end
    applyStimulus(1'b1, 5'd6, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkAll("stall_cycle", 1'b1, 5'd7, 32'h5A, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < LIMIT + 1; k++) begin
      applyStimulus(1'b1, 5'(k + 10), 32'h400 + 32'(k), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkAll($sformatf("post_stall%0d", k), 1'b1, 5'(k + 10), 32'h400 + 32'(k), 32'h0, 1'b0, 1'b1);
    end

    // Asynchronous reset with two entries buffered and two busy bits set.
    resetDut();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd21);
    applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd20, 32'hA, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'h2, 1'b1, 5'd21, 32'hB, 1'b0, 5'd0);
    checkAll("pre_reset", 1'b1, 5'd3, 32'h2, 32'h0030_0000, 1'b0, 1'b0);
    idleInputs();
    #2;
    reset_n = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkAll("reset_drained1", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkAll("reset_drained2", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic against the reference model.
    resetDut();
    modelReset();
    for (int i = 0; i < 3000; i++) begin
      logic        wv, mv, iv;
      logic [4:0]  wrd, mrd, ird;
      logic [31:0] wd, md;
      wv  = ($urandom_range(0, 99) < 70);
      wrd = 5'($urandom_range(0, 31));
      wd  = $urandom;
      mv  = ($urandom_range(0, 99) < 45);
      mrd = 5'($urandom_range(0, 31));
      md  = $urandom;
      iv  = ($urandom_range(0, 99) < 30);
      ird = 5'($urandom_range(0, 31));
      modelStep(wv, wrd, wd, mv, mrd, md, iv, ird);
      applyStimulus(wv, wrd, wd, mv, mrd, md, iv, ird);
      checkAll($sformatf("rand%0d", i), m_we, m_rd, m_wd, modelBusy(), m_stall, (mq.size() < DEPTH));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the single-issue pipeline writeback stream (MEM/WB) with out-of-order results from the multi-cycle multiply/divide unit. It drives the register file's single write port. It buffers mul/div results in a small FIFO and keeps a per-register busy scoreboard for the decode stage. It forces a one-cycle pipeline stall when a buffered result starves. It sits between MEM/WB and register_file; its registered outputs connect directly to the register file's reg_write_enable/rd/write_data.

## Interface
- DATA_WIDTH, 32, register data width
- MD_FIFO_DEPTH, 2, mul/div result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before a stall is forced
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline writeback request (MEM/WB reg_write)
- wb_rd  in  5  pipeline destination register
- wb_data  in  DATA_WIDTH  pipeline writeback value
- md_valid  in  1  mul/div result valid
- md_ready  out  1  FIFO can accept a result; equals FIFO not full
- md_rd  in  5  mul/div destination register
- md_data  in  DATA_WIDTH  mul/div result
- md_issue  in  1  decode is issuing a mul/div op this cycle
- md_issue_rd  in  5  destination register of that op
- busy_mask  out  32  bit i = 1: a mul/div result for xi is pending
- pipe_stall  out  1  registered; upstream must hold MEM/WB and present wb_valid=0 while high
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  5  register file write address (registered)
- rf_wdata  out  DATA_WIDTH  register file write data (registered)

## Operation
- Reset (reset_n=0, asynchronous): rf_we=0, rf_rd=0, rf_wdata=0, busy_mask=0, pipe_stall=0, FIFO empty, starve counter 0; md_ready=1 during and after reset. Reset mid-operation discards buffered results and clears the scoreboard.
- Enqueue: a result is accepted when md_valid && md_ready. A result with md_rd==0 is accepted and dropped (not enqueued). Enqueue and pop may occur in the same cycle; when the FIFO is full, md_ready=0 even if a pop happens that cycle (no combinational path from pop to ready).
- Arbitration, evaluated each cycle in priority order:
  1. pipe_stall==1 and FIFO non-empty: grant FIFO head; wb inputs are ignored.
  2. wb_valid && wb_rd!=0: grant the pipeline.
  3. FIFO non-empty: grant FIFO head (pop).
  4. Otherwise no grant.
- wb_valid with wb_rd==0 counts as no request, so the FIFO may drain in that cycle.
- Grant in cycle N updates rf_we=1, rf_rd, and rf_wdata at the edge ending N. The register file commits at the edge ending N+1. No grant gives rf_we=0; rf_rd and rf_wdata hold their values.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, pipe_stall is set for exactly one cycle on the next edge, then the counter clears.
- Scoreboard:
  - md_issue && md_issue_rd!=0 sets busy_mask[md_issue_rd] at the next edge.
  - A bit clears at the edge ending the cycle in which rf_we=1 from a FIFO grant addresses that register (tracked by a registered source flag).
  - Set and clear of the same bit in the same cycle: set wins.
  - busy_mask[0] is always 0.
- Hazards: decode stalls issue of any instruction whose source or destination register has its busy bit set. The arbiter does not reorder or check WAW.

## Timing
- Pipeline writeback latency: wb_valid at N gives rf_we at N+1 and the register value is committed at the end of N+1.
- Mul/div latency, FIFO empty and no competing wb: accepted at N, popped at N+1, rf_we at N+2, busy bit clear visible at N+3.
- Worst-case buffering delay is bounded by STARVE_LIMIT+1 cycles per entry.
- Throughput: one register file write per cycle; at most one enqueue per cycle.

## Test plan
- Release reset_n while md_valid=0 → rf_we=0, busy_mask=0, md_ready=1, pipe_stall=0; assert reset_n=0 mid-stream with 2 entries buffered → FIFO empty and busy_mask=0 immediately.
- wb_valid=1, wb_rd=5, wb_data=0x13 at N → rf_we=1, rf_rd=5, rf_wdata=0x13 at N+1; wb_rd=0 → rf_we stays 0.
- md_issue_rd=9, then md result (9, 0x2) with no wb traffic → busy_mask[9]=1 from the cycle after issue; rf_we with rd=9, data=0x2 two cycles after accept; bit 9 clears the following cycle.
- Simultaneous wb (8, 0x1) and md result (10, 0x13) → wb written first, md written the next cycle; a second md result while the FIFO holds one → md_ready=0 after two buffered.
- wb_valid=1 every cycle with one FIFO entry → pipe_stall=1 exactly once after 4 starved cycles; FIFO entry written in the stall cycle and counter reset.
- md_issue to rd=3 in the same cycle a FIFO write to rd=3 completes → busy_mask[3] remains 1.
